// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline boundary.
// The optional overflow counter is enabled with EX_MEM_OVF_COUNT_EN.
package ex_mem_pkg;

    localparam int NB_REG_DEF      = 32;
    localparam int NB_REG_ADDR_DEF = 5;
    localparam int NB_CAUSE_DEF    = 5;
    localparam int NB_OVF_COUNT    = 32;

    localparam logic [NB_CAUSE_DEF-1:0] CAUSE_OV = 5'd12;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } trap_state_t;

endpackage

// File: rtl/ex_ovf_trap_fsm.sv
// Overflow trap FSM: captures EPC/cause, holds the exception request and squashes
// younger instructions until acknowledged. Optional counter via EX_MEM_OVF_COUNT_EN.
//
// state | meaning
// RUN   | normal operation, watching for a trapping overflow
// TRAP  | exception pending, every capture squashed until i_exc_ack
module ex_ovf_trap_fsm
    import ex_mem_pkg::*;
#(
    parameter int NB_REG   = NB_REG_DEF,
    parameter int NB_CAUSE = NB_CAUSE_DEF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_capture,
    input  logic                    i_valid,
    input  logic                    i_ovf_trap,
    input  logic                    i_alu_oe,
    input  logic [NB_REG-1:0]       i_pc,
    input  logic                    i_exc_ack,
`ifdef EX_MEM_OVF_COUNT_EN
    output logic [NB_OVF_COUNT-1:0] o_ovf_count,
`endif
    output logic                    o_squash,
    output logic                    o_exc_req,
    output logic [NB_REG-1:0]       o_epc,
    output logic [NB_CAUSE-1:0]     o_exc_cause
);

    trap_state_t state;
    logic        ovf_hit;

    assign ovf_hit  = (state == RUN) && i_valid && i_ovf_trap && i_alu_oe;
    // In TRAP the incoming instruction is squashed even when ack arrives on the same edge.
    assign o_squash = (state == TRAP) || ovf_hit;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= RUN;
            o_exc_req   <= 1'b0;
            o_epc       <= '0;
            o_exc_cause <= '0;
`ifdef EX_MEM_OVF_COUNT_EN
            o_ovf_count <= '0;
`endif
        end else if (i_capture) begin
            case (state)
                RUN: begin
                    if (ovf_hit) begin
                        state       <= TRAP;
                        o_exc_req   <= 1'b1;
                        o_epc       <= i_pc;
                        o_exc_cause <= NB_CAUSE'(CAUSE_OV);
`ifdef EX_MEM_OVF_COUNT_EN
                        if (o_ovf_count != '1)
                            o_ovf_count <= o_ovf_count + 1'b1;
`endif
                    end
                end
                TRAP: begin
                    if (i_exc_ack) begin
                        state     <= RUN;
                        o_exc_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= RUN;
                    o_exc_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall/flush and precise arithmetic-overflow trap.
// Define EX_MEM_OVF_COUNT_EN to expose the saturating o_ovf_count output.
module ex_mem_latch
    import ex_mem_pkg::*;
#(
    parameter int NB_REG      = NB_REG_DEF,
    parameter int NB_REG_ADDR = NB_REG_ADDR_DEF,
    parameter int NB_CAUSE    = NB_CAUSE_DEF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_valid,
    input  logic [NB_REG-1:0]       i_alu_result,
    input  logic                    i_alu_zero,
    input  logic                    i_alu_oe,
    input  logic                    i_ovf_trap,
    input  logic [NB_REG-1:0]       i_store_data,
    input  logic [NB_REG_ADDR-1:0]  i_write_reg,
    input  logic                    i_reg_write,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic                    i_mem_to_reg,
    input  logic [NB_REG-1:0]       i_pc,
    input  logic                    i_exc_ack,
`ifdef EX_MEM_OVF_COUNT_EN
    output logic [NB_OVF_COUNT-1:0] o_ovf_count,
`endif
    output logic                    o_valid,
    output logic [NB_REG-1:0]       o_alu_result,
    output logic                    o_zero,
    output logic [NB_REG-1:0]       o_store_data,
    output logic [NB_REG_ADDR-1:0]  o_write_reg,
    output logic                    o_reg_write,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic                    o_mem_to_reg,
    output logic                    o_exc_req,
    output logic [NB_REG-1:0]       o_epc,
    output logic [NB_CAUSE-1:0]     o_exc_cause
);

    logic capture;
    logic squash;
    logic commit;

    assign capture = !i_flush && !i_stall;
    assign commit  = i_valid && !squash;

    ex_ovf_trap_fsm #(
        .NB_REG   (NB_REG),
        .NB_CAUSE (NB_CAUSE)
    ) u_trap_fsm (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_capture   (capture),
        .i_valid     (i_valid),
        .i_ovf_trap  (i_ovf_trap),
        .i_alu_oe    (i_alu_oe),
        .i_pc        (i_pc),
        .i_exc_ack   (i_exc_ack),
`ifdef EX_MEM_OVF_COUNT_EN
        .o_ovf_count (o_ovf_count),
`endif
        .o_squash    (squash),
        .o_exc_req   (o_exc_req),
        .o_epc       (o_epc),
        .o_exc_cause (o_exc_cause)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            o_valid      <= 1'b0;
            o_alu_result <= '0;
            o_zero       <= 1'b0;
            o_store_data <= '0;
            o_write_reg  <= '0;
            o_reg_write  <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
        end else if (!i_stall) begin
            // Data fields always load; only the controls are gated by commit.
            o_alu_result <= i_alu_result;
            o_zero       <= i_alu_zero;
            o_store_data <= i_store_data;
            o_write_reg  <= i_write_reg;
            o_valid      <= commit;
            o_reg_write  <= commit && i_reg_write;
            o_mem_read   <= commit && i_mem_read;
            o_mem_write  <= commit && i_mem_write;
            o_mem_to_reg <= commit && i_mem_to_reg;
        end
    end

endmodule

// File: tb/tb_ex_mem_latch.sv
// Scoreboard bench for ex_mem_latch: directed vectors push expected outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_ex_mem_latch;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_alu_result = '0;
    logic        i_alu_zero = 1'b0;
    logic        i_alu_oe = 1'b0;
    logic        i_ovf_trap = 1'b0;
    logic [31:0] i_store_data = '0;
    logic [4:0]  i_write_reg = '0;
    logic        i_reg_write = 1'b0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic        i_mem_to_reg = 1'b0;
    logic [31:0] i_pc = '0;
    logic        i_exc_ack = 1'b0;

    logic        o_valid;
    logic [31:0] o_alu_result;
    logic        o_zero;
    logic [31:0] o_store_data;
    logic [4:0]  o_write_reg;
    logic        o_reg_write;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_mem_to_reg;
    logic        o_exc_req;
    logic [31:0] o_epc;
    logic [4:0]  o_exc_cause;
`ifdef EX_MEM_OVF_COUNT_EN
    logic [31:0] o_ovf_count;
`endif

    typedef struct packed {
        logic        reset, stall, flush, valid;
        logic [31:0] result;
        logic        zero, oe, trap;
        logic [31:0] sdata;
        logic [4:0]  wreg;
        logic        rw, mr, mw, m2r;
        logic [31:0] pc;
        logic        ack;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic        zero;
        logic [31:0] sdata;
        logic [4:0]  wreg;
        logic        rw, mr, mw, m2r;
        logic        req;
        logic [31:0] epc;
        logic [4:0]  cause;
    } obs_t;

    obs_t        exp_q[$];
    logic [31:0] cnt_q[$];
    stim_t       s;
    int          checks = 0;
    int          failures = 0;
    int          vec_no = 0;

    ex_mem_latch dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .i_alu_result (i_alu_result),
        .i_alu_zero   (i_alu_zero),
        .i_alu_oe     (i_alu_oe),
        .i_ovf_trap   (i_ovf_trap),
        .i_store_data (i_store_data),
        .i_write_reg  (i_write_reg),
        .i_reg_write  (i_reg_write),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_mem_to_reg (i_mem_to_reg),
        .i_pc         (i_pc),
        .i_exc_ack    (i_exc_ack),
`ifdef EX_MEM_OVF_COUNT_EN
        .o_ovf_count  (o_ovf_count),
`endif
        .o_valid      (o_valid),
        .o_alu_result (o_alu_result),
        .o_zero       (o_zero),
        .o_store_data (o_store_data),
        .o_write_reg  (o_write_reg),
        .o_reg_write  (o_reg_write),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
        .o_mem_to_reg (o_mem_to_reg),
        .o_exc_req    (o_exc_req),
        .o_epc        (o_epc),
        .o_exc_cause  (o_exc_cause)
    );

    always #5 i_clock = ~i_clock;

    function automatic obs_t e(input logic v, input logic [31:0] res, input logic z,
                               input logic [31:0] sd, input logic [4:0] wr,
                               input logic rw, input logic mr, input logic mw, input logic m2r,
                               input logic req, input logic [31:0] epc, input logic [4:0] cause);
        obs_t o;
        o.valid = v;  o.result = res; o.zero = z; o.sdata = sd; o.wreg = wr;
        o.rw = rw;    o.mr = mr;      o.mw = mw;  o.m2r = m2r;
        o.req = req;  o.epc = epc;    o.cause = cause;
        return o;
    endfunction

    task automatic clr();
        s = '0;
    endtask

    task automatic step(input obs_t exp, input logic [31:0] cnt);
        @(negedge i_clock);
        i_reset = s.reset;  i_stall = s.stall;     i_flush = s.flush;   i_valid = s.valid;
        i_alu_result = s.result; i_alu_zero = s.zero; i_alu_oe = s.oe;  i_ovf_trap = s.trap;
        i_store_data = s.sdata;  i_write_reg = s.wreg; i_reg_write = s.rw;
        i_mem_read = s.mr;  i_mem_write = s.mw;    i_mem_to_reg = s.m2r;
        i_pc = s.pc;        i_exc_ack = s.ack;
        exp_q.push_back(exp);
        cnt_q.push_back(cnt);
    endtask

    // Monitor: one expected entry per rising edge, sampled 1 time unit after it.
    initial begin
        obs_t        act;
        obs_t        exp;
        logic [31:0] cnt;
        forever begin
            @(posedge i_clock);
            #1;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                cnt = cnt_q.pop_front();
                vec_no++;
                act = e(o_valid, o_alu_result, o_zero, o_store_data, o_write_reg,
                        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
                        o_exc_req, o_epc, o_exc_cause);
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL vec%0d outputs actual=%h required=%h", vec_no, act, exp);
                end
`ifdef EX_MEM_OVF_COUNT_EN
                checks++;
                if (o_ovf_count !== cnt) begin
                    failures++;
                    $display("FAIL vec%0d ovf_count actual=%0d required=%0d", vec_no, o_ovf_count, cnt);
                end
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        clr(); s.reset = 1'b1;
        step(e(0, 32'h0, 0, 32'h0, 5'd0, 0,0,0,0, 0, 32'h0, 5'd0), 32'd0);
        // plain capture
        clr(); s.valid = 1; s.result = 32'h10; s.rw = 1; s.wreg = 5'd3;
        step(e(1, 32'h10, 0, 32'h0, 5'd3, 1,0,0,0, 0, 32'h0, 5'd0), 32'd0);
        clr(); s.valid = 1; s.result = 32'hAAAA_AAAA; s.rw = 1; s.wreg = 5'd4; s.zero = 1; s.sdata = 32'h11;
        step(e(1, 32'hAAAA_AAAA, 1, 32'h11, 5'd4, 1,0,0,0, 0, 32'h0, 5'd0), 32'd0);
        // stall holds for 3 cycles
        for (int i = 0; i < 3; i++) begin
            clr(); s.stall = 1; s.valid = 1; s.result = 32'h5555_5555; s.wreg = 5'd7; s.mw = 1;
            step(e(1, 32'hAAAA_AAAA, 1, 32'h11, 5'd4, 1,0,0,0, 0, 32'h0, 5'd0), 32'd0);
        end
        // invalid capture: data loads, controls zero
        clr(); s.result = 32'h12; s.rw = 1; s.mr = 1; s.wreg = 5'd9; s.sdata = 32'h22;
        step(e(0, 32'h12, 0, 32'h22, 5'd9, 0,0,0,0, 0, 32'h0, 5'd0), 32'd0);
        // unsigned overflow commits
        clr(); s.valid = 1; s.oe = 1; s.result = 32'h8000_0000; s.rw = 1; s.wreg = 5'd5;
        step(e(1, 32'h8000_0000, 0, 32'h0, 5'd5, 1,0,0,0, 0, 32'h0, 5'd0), 32'd0);
        // trapping overflow
        clr(); s.valid = 1; s.oe = 1; s.trap = 1; s.pc = 32'h40; s.rw = 1; s.result = 32'h7FFF_FFFF; s.wreg = 5'd6; s.sdata = 32'h33;
        step(e(0, 32'h7FFF_FFFF, 0, 32'h33, 5'd6, 0,0,0,0, 1, 32'h40, 5'd12), 32'd1);
        // two younger instructions squashed, EPC frozen
        clr(); s.valid = 1; s.rw = 1; s.mw = 1; s.result = 32'h20; s.wreg = 5'd8; s.pc = 32'h44;
        step(e(0, 32'h20, 0, 32'h0, 5'd8, 0,0,0,0, 1, 32'h40, 5'd12), 32'd1);
        clr(); s.valid = 1; s.rw = 1; s.oe = 1; s.trap = 1; s.result = 32'h24; s.wreg = 5'd10; s.pc = 32'h48;
        step(e(0, 32'h24, 0, 32'h0, 5'd10, 0,0,0,0, 1, 32'h40, 5'd12), 32'd1);
        // flush + stall in TRAP: stage cleared, request stays
        clr(); s.flush = 1; s.stall = 1; s.valid = 1; s.rw = 1; s.result = 32'h99; s.wreg = 5'd2;
        step(e(0, 32'h0, 0, 32'h0, 5'd0, 0,0,0,0, 1, 32'h40, 5'd12), 32'd1);
        // ack together with a new overflow: ack wins, instruction squashed
        clr(); s.ack = 1; s.valid = 1; s.trap = 1; s.oe = 1; s.pc = 32'h50; s.result = 32'h33; s.wreg = 5'd11; s.rw = 1;
        step(e(0, 32'h33, 0, 32'h0, 5'd11, 0,0,0,0, 0, 32'h40, 5'd12), 32'd1);
        // ack in RUN ignored
        clr(); s.ack = 1; s.valid = 1; s.rw = 1; s.result = 32'h1; s.wreg = 5'd1;
        step(e(1, 32'h1, 0, 32'h0, 5'd1, 1,0,0,0, 0, 32'h40, 5'd12), 32'd1);
        // flush + stall in RUN
        clr(); s.flush = 1; s.stall = 1; s.valid = 1; s.rw = 1; s.result = 32'h77; s.wreg = 5'd7;
        step(e(0, 32'h0, 0, 32'h0, 5'd0, 0,0,0,0, 0, 32'h40, 5'd12), 32'd1);
        // load instruction controls
        clr(); s.valid = 1; s.mr = 1; s.m2r = 1; s.rw = 1; s.result = 32'h100; s.wreg = 5'd2;
        step(e(1, 32'h100, 0, 32'h0, 5'd2, 1,1,0,1, 0, 32'h40, 5'd12), 32'd1);
        // second trap, stalled ack is not sampled
        clr(); s.valid = 1; s.trap = 1; s.oe = 1; s.pc = 32'h60; s.rw = 1; s.result = 32'h5; s.wreg = 5'd3;
        step(e(0, 32'h5, 0, 32'h0, 5'd3, 0,0,0,0, 1, 32'h60, 5'd12), 32'd2);
        clr(); s.stall = 1; s.ack = 1; s.valid = 1; s.result = 32'hDEAD; s.wreg = 5'd9;
        step(e(0, 32'h5, 0, 32'h0, 5'd3, 0,0,0,0, 1, 32'h60, 5'd12), 32'd2);
        clr(); s.ack = 1; s.valid = 1; s.rw = 1; s.result = 32'h6; s.wreg = 5'd4;
        step(e(0, 32'h6, 0, 32'h0, 5'd4, 0,0,0,0, 0, 32'h60, 5'd12), 32'd2);
        // third trap then reset mid-TRAP
        clr(); s.valid = 1; s.trap = 1; s.oe = 1; s.pc = 32'h70; s.rw = 1; s.result = 32'h7; s.wreg = 5'd5;
        step(e(0, 32'h7, 0, 32'h0, 5'd5, 0,0,0,0, 1, 32'h70, 5'd12), 32'd3);
        clr(); s.reset = 1; s.valid = 1; s.rw = 1; s.result = 32'h9; s.wreg = 5'd9;
        step(e(0, 32'h0, 0, 32'h0, 5'd0, 0,0,0,0, 0, 32'h0, 5'd0), 32'd0);
        clr(); s.valid = 1; s.rw = 1; s.result = 32'h8; s.wreg = 5'd6;
        step(e(1, 32'h8, 0, 32'h0, 5'd6, 1,0,0,0, 0, 32'h0, 5'd0), 32'd0);

        clr();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge i_clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_latch.md
Name: ex_mem_latch

Overview:
EX/MEM pipeline boundary that sits directly downstream of the ALU in the 5-stage MIPS core. It registers the ALU result, zero flag, store data and MEM/WB control bits. It applies stall and flush, and turns the ALU overflow flag into a precise arithmetic-overflow exception. It holds a small trap FSM that squashes the faulting instruction and all younger instructions until the exception unit acknowledges.

Parameters:
NB_REG, 32, datapath width (ALU result, store data, PC)
NB_REG_ADDR, 5, register-file address width
NB_CAUSE, 5, exception cause code width

Ports:
i_clock  in  1  system clock, all state updates on rising edge
i_reset  in  1  synchronous reset, active-high
i_stall  in  1  hold all stage registers (from hazard unit)
i_flush  in  1  bubble: clear stage contents
i_valid  in  1  EX holds a real instruction
i_alu_result  in  NB_REG  ALU o_result
i_alu_zero  in  1  ALU o_zero
i_alu_oe  in  1  ALU o_oe overflow flag
i_ovf_trap  in  1  instruction traps on overflow (ADD/SUB/ADDI; 0 for ADDU/SUBU/ADDIU)
i_store_data  in  NB_REG  forwarded rt value for SW/SH/SB
i_write_reg  in  NB_REG_ADDR  destination register
i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  in  1 each  control bits
i_pc  in  NB_REG  PC of EX instruction
i_exc_ack  in  1  exception unit accepted the request
o_valid  out  1  MEM holds a real instruction
o_alu_result  out  NB_REG  registered result / memory address
o_zero  out  1  registered zero flag
o_store_data  out  NB_REG
o_write_reg  out  NB_REG_ADDR
o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg  out  1 each
o_exc_req  out  1  overflow exception pending (level)
o_epc  out  NB_REG  PC of faulting instruction
o_exc_cause  out  NB_CAUSE  cause code

Behaviour:
- Clocking/reset: single clock i_clock; i_reset is synchronous, active-high. On reset all outputs are 0 and the FSM is in RUN.
- Latency: 1 cycle. EX values appear on outputs the cycle after capture.
- Update priority per edge: i_reset > i_flush > i_stall > capture.
- Flush: o_valid and all four control outputs become 0. Data outputs become 0. FSM state is not changed.
- Stall: every register holds, including the FSM. Overflow is evaluated only on a capturing edge.
- Commit-enable: a capture commits controls only if i_valid=1. Otherwise the controls are zeroed; the data fields are still loaded.
- FSM states:
  - RUN: normal capture. If i_valid & i_ovf_trap & i_alu_oe on a capturing edge:
    - load o_epc <= i_pc and o_exc_cause <= CAUSE_OV (5'd12)
    - force o_valid, o_reg_write, o_mem_write, o_mem_read to 0 (faulting instruction never writes)
    - set o_exc_req=1 and go to TRAP.
  - TRAP: o_exc_req=1. Every capture is squashed (o_valid/controls = 0), because younger instructions must not commit. o_epc and o_exc_cause are frozen. Sampling i_exc_ack=1 clears o_exc_req and returns to RUN.
- If ack and a new overflow arrive on the same edge in TRAP, the ack wins and the new instruction is squashed. The front end refetches after the exception, so nothing is lost.
- i_exc_ack while in RUN: ignored.
- i_alu_oe with i_ovf_trap=0: no exception; the wrapped result is committed normally.
- Flush in TRAP: clears the stage but stays in TRAP until ack.
- Reset mid-TRAP: returns to RUN, o_exc_req=0, o_epc=0.
- All arithmetic is pass-through; no width conversion inside the block.

Optional Feature:
EX_MEM_OVF_COUNT_EN
- Defined: adds output o_ovf_count (32 bits). It increments by 1 on each RUN->TRAP transition, saturates at 32'hFFFF_FFFF, and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package ex_mem_pkg holds:
  - the FSM state type with RUN=1'b0 and TRAP=1'b1
  - the CAUSE_OV=5'd12 constant
  - the default widths
- Sub-module ex_ovf_trap_fsm holds the state register, EPC/cause registers, o_exc_req and the optional counter. It outputs a squash signal.
- The top level holds the stage registers and the priority logic.

Test Plan:
- Reset then capture: i_valid=1, result=32'h0000_0010, reg_write=1, write_reg=5'd3 -> next cycle o_valid=1, o_alu_result=32'h10, o_write_reg=3, o_exc_req=0.
- Stall: capture 32'hAAAA_AAAA, then i_stall=1 for 3 cycles with input 32'h5555_5555 -> output holds 32'hAAAA_AAAA for all 3 cycles.
- Overflow trap: i_pc=32'h0000_0040, i_ovf_trap=1, i_alu_oe=1, reg_write=1 -> next cycle:
  - o_reg_write=0, o_valid=0
  - o_exc_req=1, o_epc=32'h40, o_exc_cause=12.
  - Two following valid instructions are squashed. i_exc_ack=1 -> o_exc_req=0 the next cycle.
- Unsigned overflow: i_ovf_trap=0, i_alu_oe=1, result=32'h8000_0000 -> committed with o_reg_write=1 and no exception.
- Flush vs stall: i_flush=1 and i_stall=1 together -> o_valid=0 and controls 0 next cycle. With flush in TRAP, o_exc_req stays 1.
- Counter (EX_MEM_OVF_COUNT_EN): three trap/ack sequences -> o_ovf_count=3. Reset -> 0.
